fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the five-stage pipelined processor: holds the program counter, reads the word-addressed instruction ROM and drives the IF/ID pipeline register consumed by the decode stage. It supports decode-requested stalls and execute-requested redirects (taken branch/jump) with a one-slot flush. It also keeps a fetched-instruction counter for bench-side sanity checks.

## Interface
- `IMEM_WORDS`, 64: depth of instruction ROM in 32-bit words; power of two.
- `RESET_PC`, 32'h0: PC value loaded on reset.
- `clk` input 1: rising-edge clock.
- `reset` input 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `stall` input 1: from hazard unit in ID; freeze PC and IF/ID register.
- `redirect_valid` input 1: from EX; load `redirect_target` into PC and flush IF/ID.
- `redirect_target` input 32: new PC; bits [1:0] ignored (forced to 0).
- `pc_out` output 32: current PC (the address being fetched this cycle).
- `if_id_instr` output 32: registered instruction for ID.
- `if_id_pc` output 32: registered PC of `if_id_instr`.
- `if_id_valid` output 1: IF/ID slot holds a real instruction.
- `fetch_count` output 32: number of instructions latched into IF/ID since reset.

## Operation
- ROM is an internal array `block[0:IMEM_WORDS-1]`, instance `instr_memory`, loaded by the bench via `$readmemh`; never written by RTL. PC held in a register instance `program_counter` with output `out`.
- Combinational fetch: `fetched = block[pc_out[log2(IMEM_WORDS)+1:2]]` when `pc_out[31:2] < IMEM_WORDS`, else 32'h0 (NOP).
- Per-edge priority (highest first):
  - `reset`: PC←RESET_PC; if_id_instr←0, if_id_pc←0, if_id_valid←0; fetch_count←0.
  - `redirect_valid`: PC←{redirect_target[31:2],2'b00}; IF/ID←NOP (instr 0, pc 0, valid 0); fetch_count unchanged. Wins over `stall` in the same cycle.
  - `stall`: PC, IF/ID and fetch_count all hold.
  - otherwise: PC←PC+4 (mod 2^32); if_id_instr←fetched, if_id_pc←PC, if_id_valid←1; fetch_count←fetch_count+1 (wraps at 2^32).
- No state machine beyond the registers above; the slot state is (valid, stalled, flushed), derivable from inputs.
- PC wrap: 32'hFFFFFFFC + 4 → 32'h0, no special handling; fetch beyond ROM yields NOP with valid=1.

## Timing
- Fetch latency: instruction at address A appears on `if_id_instr` one rising edge after `pc_out == A` in a non-stalled, non-redirected cycle.
- Free-running after reset release: `pc_out` = 4·n after n unstalled edges; with 10 ns clock and reset dropped before the first edge at t=10 ns, `pc_out` at t = 5+10k ns equals 4k.
- Redirect: target visible on `pc_out` the edge after `redirect_valid`; target instruction in IF/ID one edge later; exactly one bubble (valid=0) inserted.
- Stall: outputs bit-identical for every stalled cycle; resume next edge with no lost or duplicated instruction.
- Reset mid-stream (any cycle, incl. during stall/redirect): all outputs at reset values after that edge; inputs ignored that edge.
- All outputs registered except none combinational on inputs; `pc_out` is the register value.

## Test plan
- Reset then free-run 20 cycles with ROM = words 0..19 → `pc_out` steps 0,4,8,…,76; `if_id_instr` = ROM[k] with `if_id_pc`=4k, valid=1; `fetch_count`=20.
- Stall asserted 3 cycles at PC=0x10 → `pc_out` holds 0x10, IF/ID holds ROM[3]/0xC, count frozen; after release next instr ROM[4] at pc 0x10.
- Redirect to 0x23 while PC=0x08 → next `pc_out`=0x20, IF/ID valid=0 instr=0; following edge IF/ID = ROM[8], pc 0x20.
- Simultaneous stall and redirect to 0x40 → redirect wins: `pc_out`=0x40, IF/ID flushed.
- Run PC past IMEM_WORDS·4 (0x100 for 64) → `if_id_instr`=0, valid=1, PC keeps incrementing.
- Assert reset during a stall at PC=0x30 → next edge `pc_out`=0, IF/ID=0/0/0, `fetch_count`=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, word-addressed instruction ROM and the
// IF/ID pipeline register, with decode stalls and execute-side redirects.

module fetch_rom #(
  parameter int WORDS = 64,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   data
);
  // Contents are loaded from outside the design (test harness / memory init)
  logic [31:0] block [0:WORDS-1];

  assign data = block[addr];
endmodule

module pc_reg #(
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [31:0] d,
  output logic [31:0] out
);
  always_ff @(posedge clk) begin
    if (reset)   out <= RESET_VAL;
    else if (en) out <= d;
  end
endmodule

module fetch_stage #(
  parameter int          IMEM_WORDS = 64,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);
  localparam int AW = $clog2(IMEM_WORDS);

  logic [31:0] rom_data;
  logic [31:0] fetched;
  logic        in_range;
  logic [31:0] pc_next;
  logic        pc_en;

  fetch_rom #(.WORDS(IMEM_WORDS), .AW(AW)) instr_memory (
    .addr (pc_out[AW+1:2]),
    .data (rom_data)
  );

  // Addresses past the end of the ROM fetch as NOP rather than aliasing
  assign in_range = pc_out[31:2] < 30'(IMEM_WORDS);
  assign fetched  = in_range ? rom_data : 32'h0;

  // Redirect outranks stall so a taken branch is never lost behind a hazard
  assign pc_en   = redirect_valid | ~stall;
  assign pc_next = redirect_valid ? {redirect_target[31:2], 2'b00} : pc_out + 32'd4;

  pc_reg #(.RESET_VAL(RESET_PC)) program_counter (
    .clk   (clk),
    .reset (reset),
    .en    (pc_en),
    .d     (pc_next),
    .out   (pc_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      if_id_instr <= 32'h0;
      if_id_pc    <= 32'h0;
      if_id_valid <= 1'b0;
      fetch_count <= 32'h0;
    end else if (redirect_valid) begin
      if_id_instr <= 32'h0;
      if_id_pc    <= 32'h0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if_id_instr <= fetched;
      if_id_pc    <= pc_out;
      if_id_valid <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: free-run, stall, redirect, stall+redirect,
// fetch past ROM end, PC wrap and reset during a stall.

module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc_out, if_id_instr, if_id_pc, fetch_count;
  logic        if_id_valid;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.IMEM_WORDS(64), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc_out          (pc_out),
    .if_id_instr     (if_id_instr),
    .if_id_pc        (if_id_pc),
    .if_id_valid     (if_id_valid),
    .fetch_count     (fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_val(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] ipc, input logic v, input logic [31:0] cnt);
    chk({tag, ".pc_out"},      pc_out,             pc);
    chk({tag, ".if_id_instr"}, if_id_instr,        ins);
    chk({tag, ".if_id_pc"},    if_id_pc,           ipc);
    chk({tag, ".if_id_valid"}, {31'h0, if_id_valid}, {31'h0, v});
    chk({tag, ".fetch_count"}, fetch_count,        cnt);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) dut.instr_memory.block[i] = rom_val(i);
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;

    // Reset state
    step();
    chk_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    reset = 1'b0;

    // Free run 20 cycles
    for (int k = 0; k < 20; k++) begin
      step();
      chk_all($sformatf("run%0d", k), 32'(4 * (k + 1)), rom_val(k), 32'(4 * k), 1'b1, 32'(k + 1));
    end

    // Stall 3 cycles at PC=0x10
    do_reset();
    repeat (4) step();
    chk_all("pre_stall", 32'h10, rom_val(3), 32'hC, 1'b1, 32'd4);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all($sformatf("stall%0d", k), 32'h10, rom_val(3), 32'hC, 1'b1, 32'd4);
    end
    stall = 1'b0;
    step();
    chk_all("resume", 32'h14, rom_val(4), 32'h10, 1'b1, 32'd5);

    // Redirect to 0x23 at PC=0x08 (low bits dropped)
    do_reset();
    repeat (2) step();
    chk("pre_redir.pc_out", pc_out, 32'h8);
    redirect_valid = 1'b1; redirect_target = 32'h23;
    step();
    chk_all("redir", 32'h20, 32'h0, 32'h0, 1'b0, 32'd2);
    redirect_valid = 1'b0;
    step();
    chk_all("redir_tgt", 32'h24, rom_val(8), 32'h20, 1'b1, 32'd3);

    // Stall and redirect together: redirect wins
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
    step();
    chk_all("stall_redir", 32'h40, 32'h0, 32'h0, 1'b0, 32'd3);
    stall = 1'b0; redirect_valid = 1'b0;
    step();
    chk_all("stall_redir_tgt", 32'h44, rom_val(16), 32'h40, 1'b1, 32'd4);

    // Fetch past end of ROM
    redirect_valid = 1'b1; redirect_target = 32'hF8;
    step();
    redirect_valid = 1'b0;
    step();
    chk_all("rom62", 32'hFC, rom_val(62), 32'hF8, 1'b1, 32'd5);
    step();
    chk_all("rom63", 32'h100, rom_val(63), 32'hFC, 1'b1, 32'd6);
    step();
    chk_all("past_rom", 32'h104, 32'h0, 32'h100, 1'b1, 32'd7);

    // PC wrap at 2^32
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFF;
    step();
    chk("wrap_redir.pc_out", pc_out, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    step();
    chk_all("wrap", 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b1, 32'd8);

    // Reset asserted during a stall at PC=0x30
    redirect_valid = 1'b1; redirect_target = 32'h30;
    step();
    redirect_valid = 1'b0; stall = 1'b1;
    step();
    chk_all("stall30", 32'h30, 32'h0, 32'h0, 1'b0, 32'd8);
    reset = 1'b1;
    step();
    chk_all("reset_in_stall", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    reset = 1'b0; stall = 1'b0;
    step();
    chk_all("after_reset", 32'h4, rom_val(0), 32'h0, 1'b1, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
